// File: rtl/rcc_test_cfg_loader_if.sv
// ----------------------------------------------------------------------------
// rcc_test_cfg_loader_if
// Serial shift/update handshake between an ATE/TAP-side controller (master)
// and the RCC test configuration loader (slave).
//   shift_en    : master -> slave, shift one bit per cycle while high
//   shift_in    : master -> slave, serial data, frame LSB first
//   update      : master -> slave, single-cycle commit request
//   shift_out   : slave -> master, shadow[0] for chaining
//   busy        : slave -> master, loader is in the SHIFT state
//   update_done : slave -> master, one-cycle pulse on a successful commit
//   cfg_err     : slave -> master, sticky framing/parity error
// ----------------------------------------------------------------------------
interface rcc_test_cfg_loader_if;
    logic shift_en;
    logic shift_in;
    logic update;
    logic shift_out;
    logic busy;
    logic update_done;
    logic cfg_err;

    modport master (
        output shift_en,
        output shift_in,
        output update,
        input  shift_out,
        input  busy,
        input  update_done,
        input  cfg_err
    );

    modport slave (
        input  shift_en,
        input  shift_in,
        input  update,
        output shift_out,
        output busy,
        output update_done,
        output cfg_err
    );
endinterface

// File: rtl/rcc_test_cfg_loader.sv
// ----------------------------------------------------------------------------
// rcc_test_cfg_loader
// Serial loader for the RCC at-speed test clock-configuration word. A frame is
// shifted in LSB first into a shadow register; an update commits it to the
// registered test_* outputs only when exactly one full frame was received.
//
// Ports:
//   clk, rst   : loader clock, synchronous active-high reset
//   bus        : rcc_test_cfg_loader_if.slave (shift_en, shift_in, update,
//                shift_out, busy, update_done, cfg_err)
//   test_*     : registered configuration fields driven to the RCC test mux
//
// Build option:
//   RCC_TCFG_PARITY_EN : frame grows by one trailing even-parity bit and a
//                        commit additionally requires correct parity.
// ----------------------------------------------------------------------------
module rcc_test_cfg_loader #(
    parameter int unsigned CFG_W = 70,
    parameter int unsigned CNT_W = 7
) (
    input  logic                       clk,
    input  logic                       rst,
    rcc_test_cfg_loader_if.slave       bus,
    output logic [1:0]                 test_pllsrc,
    output logic [2:0]                 test_mco1sel,
    output logic [2:0]                 test_mco2sel,
    output logic [1:0]                 test_sw,
    output logic                       test_hrtimsel,
    output logic [1:0]                 test_clkpersel,
    output logic [1:0]                 test_hsidiv,
    output logic [5:0]                 test_divm1,
    output logic [5:0]                 test_divm2,
    output logic [5:0]                 test_divm3,
    output logic [3:0]                 test_mco1pre,
    output logic [3:0]                 test_mco2pre,
    output logic [5:0]                 test_rtcpre,
    output logic [3:0]                 test_d1cpre,
    output logic [2:0]                 test_d1ppre,
    output logic [3:0]                 test_hpre,
    output logic [2:0]                 test_d2ppre1,
    output logic [2:0]                 test_d2ppre2,
    output logic [2:0]                 test_d3ppre,
    output logic                       test_timpre,
    output logic                       test_eth_rcc_fes,
    output logic                       test_eth_rcc_epis_2
);

`ifdef RCC_TCFG_PARITY_EN
    localparam int unsigned FW = CFG_W + 1;
`else
    localparam int unsigned FW = CFG_W;
`endif
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FW);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t             r_state;
    logic [FW-1:0]      r_shadow;
    logic [CNT_W-1:0]   r_cnt;
    logic [CFG_W-1:0]   r_cfg;
    logic               r_update_done;
    logic               r_cfg_err;
    logic               w_parity_ok;

    // Even parity over the whole shadow, including the trailing parity bit.
`ifdef RCC_TCFG_PARITY_EN
    assign w_parity_ok = ~(^r_shadow);
`else
    assign w_parity_ok = 1'b1;
`endif

    // Shift / hold / commit state machine with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_shadow      <= '0;
            r_cnt         <= '0;
            r_cfg         <= '0;
            r_update_done <= 1'b0;
            r_cfg_err     <= 1'b0;
        end else begin
            r_update_done <= 1'b0;
            if (bus.shift_en) begin
                // Shift always wins; a concurrent update is a protocol error
                // and must not disturb the running count.
                r_state  <= ST_SHIFT;
                r_shadow <= {bus.shift_in, r_shadow[FW-1:1]};
                if (r_cnt != CNT_MAX) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                if (bus.update) begin
                    r_cfg_err <= 1'b1;
                end
            end else if (bus.update) begin
                // Any update outside a shift returns to IDLE; only an exact,
                // parity-clean frame reaches the outputs.
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                if ((r_cnt == CNT_FULL) && w_parity_ok) begin
                    r_cfg         <= r_shadow[CFG_W-1:0];
                    r_update_done <= 1'b1;
                    r_cfg_err     <= 1'b0;
                end else begin
                    r_cfg_err     <= 1'b1;
                end
            end else if (r_cnt != '0) begin
                r_state <= ST_HOLD;
            end else begin
                r_state <= ST_IDLE;
            end
        end
    end

    assign bus.shift_out   = r_shadow[0];
    assign bus.busy        = (r_state == ST_SHIFT);
    assign bus.update_done = r_update_done;
    assign bus.cfg_err     = r_cfg_err;

    // Field map of the committed frame.
    assign test_pllsrc         = r_cfg[1:0];
    assign test_mco1sel        = r_cfg[4:2];
    assign test_mco2sel        = r_cfg[7:5];
    assign test_sw             = r_cfg[9:8];
    assign test_hrtimsel       = r_cfg[10];
    assign test_clkpersel      = r_cfg[12:11];
    assign test_hsidiv         = r_cfg[14:13];
    assign test_divm1          = r_cfg[20:15];
    assign test_divm2          = r_cfg[26:21];
    assign test_divm3          = r_cfg[32:27];
    assign test_mco1pre        = r_cfg[36:33];
    assign test_mco2pre        = r_cfg[40:37];
    assign test_rtcpre         = r_cfg[46:41];
    assign test_d1cpre         = r_cfg[50:47];
    assign test_d1ppre         = r_cfg[53:51];
    assign test_hpre           = r_cfg[57:54];
    assign test_d2ppre1        = r_cfg[60:58];
    assign test_d2ppre2        = r_cfg[63:61];
    assign test_d3ppre         = r_cfg[66:64];
    assign test_timpre         = r_cfg[67];
    assign test_eth_rcc_fes    = r_cfg[68];
    assign test_eth_rcc_epis_2 = r_cfg[69];

endmodule

// File: tb/tb_rcc_test_cfg_loader.sv
// ----------------------------------------------------------------------------
// tb_rcc_test_cfg_loader
// Directed self-checking bench for rcc_test_cfg_loader. Expected outputs of
// each update are pushed to a scoreboard queue when the update is driven and
// popped for comparison after the commit edge.
// Honours RCC_TCFG_PARITY_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_rcc_test_cfg_loader;
    localparam int unsigned CFG_W = 70;
`ifdef RCC_TCFG_PARITY_EN
    localparam int unsigned FW = CFG_W + 1;
`else
    localparam int unsigned FW = CFG_W;
`endif

    typedef struct packed {
        logic [CFG_W-1:0] cfg;
        logic             done;
        logic             err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rcc_test_cfg_loader_if bus ();

    logic [1:0] test_pllsrc, test_sw, test_clkpersel, test_hsidiv;
    logic [2:0] test_mco1sel, test_mco2sel, test_d1ppre, test_d2ppre1, test_d2ppre2, test_d3ppre;
    logic [3:0] test_mco1pre, test_mco2pre, test_d1cpre, test_hpre;
    logic [5:0] test_divm1, test_divm2, test_divm3, test_rtcpre;
    logic       test_hrtimsel, test_timpre, test_eth_rcc_fes, test_eth_rcc_epis_2;

    rcc_test_cfg_loader #(.CFG_W(CFG_W), .CNT_W(7)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .bus                 (bus),
        .test_pllsrc         (test_pllsrc),
        .test_mco1sel        (test_mco1sel),
        .test_mco2sel        (test_mco2sel),
        .test_sw             (test_sw),
        .test_hrtimsel       (test_hrtimsel),
        .test_clkpersel      (test_clkpersel),
        .test_hsidiv         (test_hsidiv),
        .test_divm1          (test_divm1),
        .test_divm2          (test_divm2),
        .test_divm3          (test_divm3),
        .test_mco1pre        (test_mco1pre),
        .test_mco2pre        (test_mco2pre),
        .test_rtcpre         (test_rtcpre),
        .test_d1cpre         (test_d1cpre),
        .test_d1ppre         (test_d1ppre),
        .test_hpre           (test_hpre),
        .test_d2ppre1        (test_d2ppre1),
        .test_d2ppre2        (test_d2ppre2),
        .test_d3ppre         (test_d3ppre),
        .test_timpre         (test_timpre),
        .test_eth_rcc_fes    (test_eth_rcc_fes),
        .test_eth_rcc_epis_2 (test_eth_rcc_epis_2)
    );

    // Outputs reassembled into frame order for whole-word comparison.
    wire [CFG_W-1:0] obs_cfg = {test_eth_rcc_epis_2, test_eth_rcc_fes, test_timpre,
                                test_d3ppre, test_d2ppre2, test_d2ppre1, test_hpre,
                                test_d1ppre, test_d1cpre, test_rtcpre, test_mco2pre,
                                test_mco1pre, test_divm3, test_divm2, test_divm1,
                                test_hsidiv, test_clkpersel, test_hrtimsel, test_sw,
                                test_mco2sel, test_mco1sel, test_pllsrc};

    int unsigned   n_vec = 0;
    int unsigned   n_err = 0;
    exp_t          sb_q[$];

    // Reference model state.
    logic [FW-1:0]    m_shadow;
    int unsigned      m_cnt;
    logic [CFG_W-1:0] m_cfg;
    logic             m_err;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [CFG_W-1:0] obs, input logic [CFG_W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] ext(input logic [CFG_W-1:0] f);
`ifdef RCC_TCFG_PARITY_EN
        return {^f, f};
`else
        return f;
`endif
    endfunction

    function automatic logic parity_ok(input logic [FW-1:0] s);
`ifdef RCC_TCFG_PARITY_EN
        return ~(^s);
`else
        return (s == s);
`endif
    endfunction

    task automatic model_reset();
        m_shadow = '0;
        m_cnt    = 0;
        m_cfg    = '0;
        m_err    = 1'b0;
    endtask

    task automatic shift_bit(input logic b, input logic upd);
        bus.shift_en = 1'b1;
        bus.shift_in = b;
        bus.update   = upd;
        m_shadow     = {b, m_shadow[FW-1:1]};
        if (m_cnt < 127) m_cnt++;
        if (upd) m_err = 1'b1;
        tick();
        bus.shift_en = 1'b0;
        bus.shift_in = 1'b0;
        bus.update   = 1'b0;
    endtask

    // Shift bits [lo, hi) of f, then one idle cycle so the loader sits in HOLD.
    task automatic shift_range(input logic [FW-1:0] f, input int lo, input int hi);
        for (int i = lo; i < hi; i++) shift_bit(f[i], 1'b0);
        tick();
    endtask

    task automatic do_update(input string tag);
        exp_t e;
        bus.update = 1'b1;
        if ((m_cnt == FW) && parity_ok(m_shadow)) begin
            m_cfg  = m_shadow[CFG_W-1:0];
            m_err  = 1'b0;
            e.done = 1'b1;
        end else begin
            m_err  = 1'b1;
            e.done = 1'b0;
        end
        m_cnt = 0;
        e.cfg = m_cfg;
        e.err = m_err;
        sb_q.push_back(e);
        tick();
        bus.update = 1'b0;
        e = sb_q.pop_front();
        chk ({tag, ".cfg"},  obs_cfg,         e.cfg);
        chk1({tag, ".done"}, bus.update_done, e.done);
        chk1({tag, ".err"},  bus.cfg_err,     e.err);
    endtask

    task automatic quiet_chk(input string tag);
        tick();
        chk1({tag, ".done_clr"}, bus.update_done, 1'b0);
        chk1({tag, ".busy"},     bus.busy,        1'b0);
    endtask

    logic [CFG_W-1:0] fa, fb, fc, fd;
    logic [FW-1:0]    w;

    initial begin
        bus.shift_en = 1'b0;
        bus.shift_in = 1'b0;
        bus.update   = 1'b0;
        rst          = 1'b1;
        model_reset();

        fa = '0;
        fa[9:8]   = 2'b11;
        fa[20:15] = 6'd32;
        fa[57:54] = 4'b1000;
        fa[69]    = 1'b1;
        fb = CFG_W'({$urandom(), $urandom(), $urandom()});
        fc = CFG_W'({$urandom(), $urandom(), $urandom()});
        fc[0] = 1'b1;
        fd = CFG_W'({$urandom(), $urandom(), $urandom()});

        // Reset then idle.
        tick(); tick();
        rst = 1'b0;
        repeat (5) tick();
        chk ("rst.cfg",       obs_cfg,         '0);
        chk1("rst.done",      bus.update_done, 1'b0);
        chk1("rst.err",       bus.cfg_err,     1'b0);
        chk1("rst.busy",      bus.busy,        1'b0);
        chk1("rst.shift_out", bus.shift_out,   1'b0);

        // Frame A: a few named fields set.
        w = ext(fa);
        shift_bit(w[0], 1'b0);
        chk1("a.busy_shift", bus.busy, 1'b1);
        shift_range(w, 1, FW);
        chk1("a.busy_hold", bus.busy, 1'b0);
        do_update("a");
        chk ("a.sw",     CFG_W'(test_sw),             CFG_W'(2'b11));
        chk ("a.divm1",  CFG_W'(test_divm1),          CFG_W'(6'd32));
        chk ("a.hpre",   CFG_W'(test_hpre),           CFG_W'(4'b1000));
        chk1("a.epis2",  test_eth_rcc_epis_2,         1'b1);
        chk ("a.pllsrc", CFG_W'(test_pllsrc),         '0);
        quiet_chk("a");

        // Short frame, then a full one.
        w = ext(fb);
        shift_range(w, 0, FW - 1);
        do_update("short");
        quiet_chk("short");
        shift_range(w, 0, FW);
        do_update("b");
        quiet_chk("b");

        // Overlong frame is rejected.
        shift_range(w, 0, FW);
        shift_range(w, 0, 1);
        do_update("long");
        quiet_chk("long");

        // Update during shift at bit 10 is ignored; shift continues.
        w = ext(fc);
        for (int i = 0; i < 10; i++) shift_bit(w[i], 1'b0);
        shift_bit(w[10], 1'b1);
        chk1("mid.err",  bus.cfg_err,     1'b1);
        chk1("mid.done", bus.update_done, 1'b0);
        chk ("mid.cfg",  obs_cfg,         m_cfg);
        shift_range(w, 11, FW);
        chk1("c.shift_out", bus.shift_out, w[0]);
        do_update("c");
        quiet_chk("c");

        // Reset at bit 40.
        w = ext(fd);
        for (int i = 0; i < 40; i++) shift_bit(w[i], 1'b0);
        bus.shift_en = 1'b1;
        bus.shift_in = w[40];
        rst          = 1'b1;
        tick();
        rst          = 1'b0;
        bus.shift_en = 1'b0;
        bus.shift_in = 1'b0;
        model_reset();
        chk ("rst40.cfg",       obs_cfg,       '0);
        chk1("rst40.err",       bus.cfg_err,   1'b0);
        chk1("rst40.busy",      bus.busy,      1'b0);
        chk1("rst40.shift_out", bus.shift_out, 1'b0);
        do_update("rst40.upd");
        quiet_chk("rst40.upd");

        // Back-to-back updates: second sees IDLE.
        w = ext(fd);
        shift_range(w, 0, FW);
        do_update("b2b.1");
        do_update("b2b.2");
        quiet_chk("b2b");

`ifdef RCC_TCFG_PARITY_EN
        // Good parity commits; flipped parity is rejected.
        w = ext(fa);
        shift_range(w, 0, FW);
        do_update("par.good");
        quiet_chk("par.good");
        w = ext(fb);
        w[FW-1] = ~w[FW-1];
        shift_range(w, 0, FW);
        do_update("par.bad");
        quiet_chk("par.bad");
`endif

        chk("sb.empty", CFG_W'(sb_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rcc_test_cfg_loader.md
# rcc_test_cfg_loader

Serial loader that produces the `test_*` clock-configuration word for the RCC at-speed test path. It drives the test-side inputs of the RCC configuration mux. An ATE/TAP-side controller shifts a 70-bit frame in LSB-first and then issues an update. The update commits the frame to the registered `test_*` outputs only when exactly one full frame has been received, so the clock tree never sees a partial or misaligned configuration.

## Interface
Parameters:
- `CFG_W`, 70: configuration frame width. Fixed; equals the sum of the field widths below.
- `CNT_W`, 7: width of the shift bit counter. The counter saturates at 2^CNT_W−1.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  loader clock.
- `rst`  in  1  synchronous, active-high reset.
- `shift_en`  in  1  while high, one bit is shifted per cycle.
- `shift_in`  in  1  serial data, LSB of the frame first.
- `update`  in  1  single-cycle commit request.
- `shift_out`  out  1  `shadow[0]`, for chaining to the next loader.
- `busy`  out  1  high in the SHIFT state.
- `update_done`  out  1  one-cycle pulse on a successful commit.
- `cfg_err`  out  1  sticky error flag.
- Registered configuration outputs, with frame bit offsets:
  - `test_pllsrc[1:0]` @1:0, `test_mco1sel[2:0]` @4:2, `test_mco2sel[2:0]` @7:5, `test_sw[1:0]` @9:8, `test_hrtimsel` @10, `test_clkpersel[1:0]` @12:11
  - `test_hsidiv[1:0]` @14:13, `test_divm1[5:0]` @20:15, `test_divm2[5:0]` @26:21, `test_divm3[5:0]` @32:27
  - `test_mco1pre[3:0]` @36:33, `test_mco2pre[3:0]` @40:37, `test_rtcpre[5:0]` @46:41, `test_d1cpre[3:0]` @50:47, `test_d1ppre[2:0]` @53:51, `test_hpre[3:0]` @57:54
  - `test_d2ppre1[2:0]` @60:58, `test_d2ppre2[2:0]` @63:61, `test_d3ppre[2:0]` @66:64, `test_timpre` @67, `test_eth_rcc_fes` @68, `test_eth_rcc_epis_2` @69

## Operation
- Shadow register `shadow[FW-1:0]`:
  - FW = CFG_W normally, CFG_W+1 with parity enabled (see Configuration).
  - Each shift cycle: `shadow <= {shift_in, shadow[FW-1:1]}`.
  - After FW shifts, the first bit shifted in sits at bit 0.
- Bit counter `cnt`:
  - Increments on each shift cycle and saturates at 2^CNT_W−1.
  - Cleared by reset and by any update.
- FSM states:
  - IDLE: `cnt == 0`.
  - SHIFT: `shift_en` high.
  - HOLD: `shift_en` low with `cnt > 0`.
- FSM transitions:
  - IDLE→SHIFT and HOLD→SHIFT on `shift_en`.
  - SHIFT→HOLD when `shift_en` falls.
  - HOLD→IDLE on `update`.
  - Shifting may resume from HOLD; the count continues.
- Update handling:
  - Update in HOLD with `cnt == FW` (and parity OK when enabled) → commit:
    - `test_*` <= `shadow[CFG_W-1:0]`.
    - Pulse `update_done`.
    - Clear `cfg_err`.
  - Update in HOLD with `cnt != FW` → no commit; set `cfg_err`; `test_*` hold.
  - Update in IDLE → set `cfg_err`; no commit.
  - Update while `shift_en` is high → the shift is performed, the update is ignored, `cfg_err` is set, and `cnt` is not cleared.
- `cfg_err` clears only on reset or on the next successful commit.
- The shadow contents are not cleared on update; only `cnt` is.

## Timing
- Reset values:
  - All `test_*` = 0.
  - `shadow` = 0, `cnt` = 0, state = IDLE.
  - `update_done`, `cfg_err`, `busy`, `shift_out` = 0.
- Shift: `shadow` updates on the clock edge sampling `shift_en=1`; `shift_out` reflects the new `shadow[0]` the next cycle.
- Commit latency:
  - Update sampled at edge N → `test_*` change and `update_done`=1 after edge N.
  - `update_done` returns to 0 after edge N+1.
  - Back-to-back updates: the second one sees IDLE → error.
- Reset asserted mid-shift or coincident with update: reset wins; outputs return to reset values at that edge.
- `busy` is registered and equals (state == SHIFT).

## Configuration
- `RCC_TCFG_PARITY_EN` defined:
  - FW = CFG_W+1; the final bit shifted is an even-parity bit.
  - A commit additionally requires the XOR of all FW shadow bits to be 0; a parity failure sets `cfg_err` and `test_*` hold.
- `RCC_TCFG_PARITY_EN` undefined:
  - FW = CFG_W; no parity bit and no parity check.

## Test plan
- Reset, then idle 5 cycles → all `test_*` = 0; `update_done`=0; `cfg_err`=0.
- Shift a 70-bit frame setting `sw`=2'b11, `divm1`=6'd32, `hpre`=4'b1000, `eth_rcc_epis_2`=1 (others 0), then update → one cycle later those exact fields are set and all others are 0; `update_done` pulses exactly one cycle.
- Shift 69 bits, then update → `cfg_err`=1 and `test_*` unchanged. Then shift a correct 70-bit frame and update → commit occurs and `cfg_err`=0.
- Assert update in the same cycle as `shift_en` during bit 10 of a frame → update ignored; `cfg_err`=1; the shift continues. Completing the frame and updating → successful commit.
- Assert `rst` at bit 40 of a frame → all outputs return to 0 and state is IDLE; a subsequent update alone → `cfg_err`=1.
- With `RCC_TCFG_PARITY_EN`: a 71-bit frame with correct parity → commit. The same frame with the parity bit flipped → `cfg_err`=1, no commit.
